// File: rtl/scmp_ptr_unit_if.sv
// Command/bus interface between the SC/MP instruction sequencer and the pointer unit.
// valid/ready: a command transfers on a rising clk edge where cmd_valid && cmd_ready; cmd_* and din are sampled only on that edge.
interface scmp_ptr_unit_if #(
  parameter int ADDR_W = 16
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [2:0]        cmd_sel;
  logic [7:0]        cmd_disp;
  logic [7:0]        ext_reg;
  logic [ADDR_W-1:0] din;
  logic [7:0]        dout;
  logic              done;
  logic [ADDR_W-1:0] addr;

  modport master (
    output cmd_valid, cmd_op, cmd_sel, cmd_disp, ext_reg, din,
    input  cmd_ready, dout, done, addr
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_sel, cmd_disp, ext_reg, din,
    output cmd_ready, dout, done, addr
  );
endinterface

// File: rtl/scmp_ptr_unit.sv
// SC/MP pointer register file and byte-serial effective-address unit (P0 = PC).
// Optional macro SCMP_AUTOIDX_EN enables AUTO pointer writeback; otherwise AUTO behaves as EA.
module scmp_ptr_unit #(
  parameter int NPTR     = 4,
  parameter int ADDR_W   = 16,
  parameter int OFFSET_W = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  scmp_ptr_unit_if.slave bus,
  output logic [1:0] o_dbg_state
);
  localparam int SEL_W = (NPTR > 1) ? $clog2(NPTR) : 1;
  localparam int HI_W  = ADDR_W - 8;
  // Offset bits above bit 7; the remaining upper bits are the page and never change on arithmetic.
  localparam logic [HI_W-1:0] OFF_HI_M = HI_W'((1 << (OFFSET_W - 8)) - 1);
  localparam logic [3:0]      NPTR_L   = 4'(NPTR);

  typedef enum logic [2:0] {
    OP_NOP, OP_INCPC, OP_EA, OP_AUTO, OP_XPAL, OP_XPAH, OP_XPPC, OP_LOAD
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2
  } state_t;

  state_t            r_state;
  op_t               r_op;
  logic [SEL_W-1:0]  r_sel;
  logic [7:0]        r_d;
  logic [7:0]        r_lo;
  logic              r_carry;
  logic [ADDR_W-1:0] r_ptr [NPTR];
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_dout;
  logic              r_done;

  logic              w_accept;
  op_t               w_op;
  logic [SEL_W-1:0]  w_sel;
  logic [7:0]        w_disp;
  logic [ADDR_W-1:0] w_cur;
  logic [8:0]        w_lo_sum;
  logic [HI_W-1:0]   w_hi_sum;
  logic [ADDR_W-1:0] w_wrap;

  assign w_accept = bus.cmd_valid && (r_state == S_IDLE);
  assign w_op     = op_t'(bus.cmd_op);
  assign w_sel    = ({1'b0, bus.cmd_sel} < NPTR_L) ? bus.cmd_sel[SEL_W-1:0] : '0;

  // E replaces the 0x80 displacement only for non-PC pointers; INCPC is always +1.
  always_comb begin
    w_disp = bus.cmd_disp;
    if (w_op == OP_INCPC)
      w_disp = 8'h01;
    else if ((bus.cmd_disp == 8'h80) && (bus.cmd_sel != 3'd0))
      w_disp = bus.ext_reg;
  end

  assign w_cur    = r_ptr[r_sel];
  assign w_lo_sum = {1'b0, w_cur[7:0]} + {1'b0, r_d};
  assign w_hi_sum = w_cur[ADDR_W-1:8] + {HI_W{r_d[7]}} + HI_W'(r_carry);
  assign w_wrap   = {(w_cur[ADDR_W-1:8] & ~OFF_HI_M) | (w_hi_sum & OFF_HI_M), r_lo};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= OP_NOP;
      r_sel   <= '0;
      r_d     <= 8'h00;
      r_lo    <= 8'h00;
      r_carry <= 1'b0;
      r_addr  <= '0;
      r_dout  <= 8'h00;
      r_done  <= 1'b0;
      for (int i = 0; i < NPTR; i++) r_ptr[i] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op  <= w_op;
            r_sel <= (w_op == OP_INCPC) ? '0 : w_sel;
            r_d   <= w_disp;
            case (w_op)
              OP_INCPC, OP_EA, OP_AUTO: r_state <= S_LO;
              OP_XPAL: begin
                r_dout             <= r_ptr[w_sel][7:0];
                r_ptr[w_sel][7:0]  <= bus.din[7:0];
                r_done             <= 1'b1;
              end
              OP_XPAH: begin
                r_dout                   <= 8'(r_ptr[w_sel][ADDR_W-1:8]);
                r_ptr[w_sel][ADDR_W-1:8] <= bus.din[HI_W-1:0];
                r_done                   <= 1'b1;
              end
              OP_XPPC: begin
                r_ptr[0]     <= r_ptr[w_sel];
                r_ptr[w_sel] <= r_ptr[0];
                r_done       <= 1'b1;
              end
              OP_LOAD: begin
                r_ptr[w_sel] <= bus.din;
                r_done       <= 1'b1;
              end
              default: r_done <= 1'b1;
            endcase
          end
        end
        S_LO: begin
          r_lo    <= w_lo_sum[7:0];
          r_carry <= w_lo_sum[8];
          r_done  <= 1'b1;
          r_state <= S_HI;
        end
        S_HI: begin
          r_state <= S_IDLE;
          case (r_op)
            OP_INCPC: begin
              r_ptr[0] <= w_wrap;
              r_addr   <= w_wrap;
            end
`ifdef SCMP_AUTOIDX_EN
            OP_EA: r_addr <= w_wrap;
            // Negative displacement pre-decrements; non-negative post-increments.
            OP_AUTO: begin
              r_ptr[r_sel] <= w_wrap;
              r_addr       <= r_d[7] ? w_wrap : w_cur;
            end
`else
            OP_EA, OP_AUTO: r_addr <= w_wrap;
`endif
            default: r_addr <= r_addr;
          endcase
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.done      = r_done;
  assign bus.addr      = r_addr;
  assign bus.dout      = r_dout;
  assign o_dbg_state   = r_state;
endmodule
